// File: rtl/rc_input_buffer.sv
// Per-VC router input buffer: circular flit FIFO feeding rc_unit, with RC/VA/ACTIVE packet sequencing.
// Optional sticky protocol checking is built when RC_INPUT_BUFFER_ERROR_CHECK_EN is defined.

module rc_input_buffer #(
   parameter int BUFFER_SIZE = 8,
   parameter int DEST_X_W    = 3,
   parameter int DEST_Y_W    = 3,
   parameter int PAYLOAD_W   = 16,
   parameter int VC_W        = 2,
   localparam int FLIT_W     = 2 + DEST_X_W + DEST_Y_W + PAYLOAD_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FLIT_W-1:0]   data_i,
   input  logic                valid_flag_i,
   input  logic                read_i,
   output logic [DEST_X_W-1:0] x_dest_o,
   output logic [DEST_Y_W-1:0] y_dest_o,
   input  logic [2:0]          out_port_i,
   output logic [2:0]          out_port_o,
   output logic                va_request_o,
   input  logic                vc_valid_i,
   input  logic [VC_W-1:0]     vc_new_i,
   output logic [VC_W-1:0]     vc_new_o,
   output logic [FLIT_W-1:0]   data_o,
   output logic                is_valid_o,
   output logic                is_full_o,
   output logic                is_empty_o,
   output logic                error_o
);

   // state    | meaning
   // S_IDLE   | no packet in progress, waiting for a front flit
   // S_RC     | sample rc_unit result for the front (head) flit
   // S_VA     | request a downstream VC until granted
   // S_ACTIVE | release packet flits to the switch stage until the tail pops

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] T_HEAD     = 2'b00;
   localparam logic [1:0] T_BODY     = 2'b01;
   localparam logic [1:0] T_TAIL     = 2'b10;
   localparam logic [1:0] T_HEADTAIL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RC,
      S_VA,
      S_ACTIVE
   } state_t;

   state_t              state_q, state_d;
   logic [FLIT_W-1:0]   mem [BUFFER_SIZE];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                wr_en, rd_en;
   logic [FLIT_W-1:0]   front;
   logic [1:0]          front_type;
   logic                front_is_tail;
   logic [2:0]          out_port_q;
   logic [VC_W-1:0]     vc_new_q;

   assign front         = mem[rd_ptr_q];
   assign front_type    = front[FLIT_W-1 -: 2];
   assign front_is_tail = (front_type == T_TAIL) || (front_type == T_HEADTAIL);

   assign data_o       = front;
   assign x_dest_o     = front[FLIT_W-3 -: DEST_X_W];
   assign y_dest_o     = front[PAYLOAD_W +: DEST_Y_W];
   assign is_full_o    = (count_q == CNT_W'(BUFFER_SIZE));
   assign is_empty_o   = (count_q == '0);
   assign is_valid_o   = (state_q == S_ACTIVE) && !is_empty_o;
   assign va_request_o = (state_q == S_VA);
   assign out_port_o   = out_port_q;
   assign vc_new_o     = vc_new_q;

   // Full is judged on the pre-pop count, so a full FIFO drops a write even if it pops this cycle.
   assign wr_en = valid_flag_i && !is_full_o;
   assign rd_en = read_i && is_valid_o;

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!is_empty_o) begin
               state_d = S_RC;
            end
         end
         S_RC: begin
            state_d = S_VA;
         end
         S_VA: begin
            if (vc_valid_i) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // A queued follow-on packet goes straight to routing without an idle cycle.
            if (rd_en && front_is_tail) begin
               state_d = (count_d != '0) ? S_RC : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         out_port_q <= '0;
         vc_new_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_RC) begin
            out_port_q <= out_port_i;
         end
         if ((state_q == S_VA) && vc_valid_i) begin
            vc_new_q <= vc_new_i;
         end
      end
   end

`ifdef RC_INPUT_BUFFER_ERROR_CHECK_EN
   logic first_flit_q;
   logic error_q;
   logic err_set;
   logic front_is_head;

   assign front_is_head = (front_type == T_HEAD) || (front_type == T_HEADTAIL);

   always_comb begin
      err_set = 1'b0;
      if (valid_flag_i && is_full_o) begin
         err_set = 1'b1;
      end
      if ((state_q == S_IDLE) && !is_empty_o &&
          ((front_type == T_BODY) || (front_type == T_TAIL))) begin
         err_set = 1'b1;
      end
      if (rd_en && front_is_head && !first_flit_q) begin
         err_set = 1'b1;
      end
   end

   // first_flit_q marks that the next pop in ACTIVE is the packet's head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_flit_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         if ((state_q == S_VA) && vc_valid_i) begin
            first_flit_q <= 1'b1;
         end else if (rd_en) begin
            first_flit_q <= 1'b0;
         end
         if (err_set) begin
            error_q <= 1'b1;
         end
      end
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule
